ascon_round_sequencer: RTL and testbench

Control FSM that runs one ASCON permutation (p12 or p8) on request, sitting between the ASCON top-level FSM and the datapath. It sits on the opposite side of the round-counter interface from the double round counter: it drives the counter's `en`, `init_p12` and `init_p8` inputs, and it consumes the counter's 4-bit round index. From that index it sequences the permutation rounds, steers the first-round input mux, and signals completion to the requester through a ready/start handshake.

---
 rtl/ascon_round_sequencer.sv | 101 ++++++++++
 tb/tb_ascon_round_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ascon_round_sequencer.sv
// Round sequencer for one ASCON permutation (p12 or p8); drives the external round counter and datapath strobes.
// Optional build macro ASCON_ROUND_CONST_EN adds the round_const_o output.
module ascon_round_sequencer (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       mode_p8_i,
  input  logic       abort_i,
  input  logic [3:0] cpt_i,
  output logic       ready_o,
  output logic       busy_o,
  output logic       en_cpt_o,
  output logic       init_p12_o,
  output logic       init_p8_o,
  output logic       round_en_o,
  output logic       first_round_o,
  output logic       done_o,
`ifdef ASCON_ROUND_CONST_EN
  output logic [7:0] round_const_o,
`endif
  output logic       err_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [3:0] LAST_IDX = 4'd11;

  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic       first_reg;
  logic       first_next;

  // The requested mode only matters on the acceptance cycle: the counter load
  // carries it from then on, so the sequencer keeps no copy of it.
  always_comb begin
    state_next    = state_reg;
    ready_o       = 1'b0;
    busy_o        = 1'b0;
    en_cpt_o      = 1'b0;
    init_p12_o    = 1'b0;
    init_p8_o     = 1'b0;
    round_en_o    = 1'b0;
    first_round_o = 1'b0;
    done_o        = 1'b0;
    err_o         = 1'b0;
    if (!reset_i) begin
      case (state_reg)
        ST_IDLE: begin
          ready_o = 1'b1;
          if (start_i) begin
            en_cpt_o   = 1'b1;
            init_p12_o = !mode_p8_i;
            init_p8_o  = mode_p8_i;
            state_next = ST_ROUND;
          end
        end
        ST_ROUND: begin
          busy_o        = 1'b1;
          first_round_o = first_reg;
          if (abort_i) begin
            state_next = ST_IDLE;
          end else if (cpt_i > LAST_IDX) begin
            err_o      = 1'b1;
            state_next = ST_IDLE;
          end else if (cpt_i == LAST_IDX) begin
            // Counter must hold at 11 so the next run's init pulse is the only thing that moves it.
            round_en_o = 1'b1;
            state_next = ST_DONE;
          end else begin
            round_en_o = 1'b1;
            en_cpt_o   = 1'b1;
          end
        end
        ST_DONE: begin
          done_o     = 1'b1;
          state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign first_next = (state_reg == ST_IDLE) && (state_next == ST_ROUND);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_reg <= ST_IDLE;
      first_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      first_reg <= first_next;
    end
  end

`ifdef ASCON_ROUND_CONST_EN
  assign round_const_o = round_en_o ? {4'hF - cpt_i, cpt_i} : 8'h00;
`endif

endmodule

// File: tb/tb_ascon_round_sequencer.sv
// Table-driven cycle-by-cycle bench for ascon_round_sequencer with a behavioural round counter attached.
module tb_ascon_round_sequencer;

  logic       clock_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       start_i = 1'b0;
  logic       mode_p8_i = 1'b0;
  logic       abort_i = 1'b0;
  logic       force_err = 1'b0;
  logic [3:0] cpt_i;
  logic       ready_o, busy_o, en_cpt_o, init_p12_o, init_p8_o;
  logic       round_en_o, first_round_o, done_o, err_o;
  logic [7:0] rc;

  always #5 clock_i = ~clock_i;

  // Round counter: not reset, starts stale at 7.
  logic [3:0] cnt_reg = 4'd7;
  always_ff @(posedge clock_i) begin
    if (en_cpt_o) begin
      if (init_p12_o)     cnt_reg <= 4'd0;
      else if (init_p8_o) cnt_reg <= 4'd4;
      else                cnt_reg <= cnt_reg + 4'd1;
    end
  end
  assign cpt_i = force_err ? 4'd13 : cnt_reg;

  ascon_round_sequencer dut (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .start_i       (start_i),
    .mode_p8_i     (mode_p8_i),
    .abort_i       (abort_i),
    .cpt_i         (cpt_i),
    .ready_o       (ready_o),
    .busy_o        (busy_o),
    .en_cpt_o      (en_cpt_o),
    .init_p12_o    (init_p12_o),
    .init_p8_o     (init_p8_o),
    .round_en_o    (round_en_o),
    .first_round_o (first_round_o),
    .done_o        (done_o),
`ifdef ASCON_ROUND_CONST_EN
    .round_const_o (rc),
`endif
    .err_o         (err_o)
  );

`ifndef ASCON_ROUND_CONST_EN
  assign rc = 8'h00;
`endif

  // ctl bit order: {ready, busy, en_cpt, init_p12, init_p8, round_en, first, done, err}
  typedef struct {
    logic       rst;
    logic       start;
    logic       mode;
    logic       abort;
    logic       frc;
    logic [8:0] exp_ctl;
    logic [3:0] exp_cpt;
    logic [7:0] exp_rc;
  } vec_t;

  vec_t  vecs[$];
  string tags[$];
  int    tests_run = 0;
  int    tests_failed = 0;

  function automatic void push(input string tag, input logic rst, input logic start,
                               input logic mode, input logic abort, input logic frc,
                               input logic [8:0] ctl, input logic [3:0] cpt);
    vec_t v;
    v.rst     = rst;
    v.start   = start;
    v.mode    = mode;
    v.abort   = abort;
    v.frc     = frc;
    v.exp_ctl = ctl;
    v.exp_cpt = cpt;
    v.exp_rc  = ctl[3] ? {4'hF - cpt, cpt} : 8'h00;
    vecs.push_back(v);
    tags.push_back(tag);
  endfunction

  function automatic void f_idle(input logic abort, input logic [3:0] cpt);
    push("idle", 1'b0, 1'b0, 1'b0, abort, 1'b0, 9'b1_0000_0000, cpt);
  endfunction

  function automatic void f_accept(input logic mode, input logic [3:0] cpt);
    push(mode ? "accept_p8" : "accept_p12", 1'b0, 1'b1, mode, 1'b0, 1'b0,
         {1'b1, 1'b0, 1'b1, ~mode, mode, 4'b0000}, cpt);
  endfunction

  function automatic void f_rounds(input int run_first, input int lo, input int hi,
                                   input logic start, input logic mode);
    for (int i = lo; i <= hi; i++) begin
      push("round", 1'b0, start, mode, 1'b0, 1'b0,
           {2'b01, (i != 11), 2'b00, 1'b1, (i == run_first), 2'b00}, 4'(i));
    end
  endfunction

  function automatic void f_done(input logic start, input logic mode);
    push("done", 1'b0, start, mode, 1'b0, 1'b0, 9'b0_0000_0010, 4'd11);
  endfunction

  logic [8:0] act_ctl;

  initial begin
    // Reset (start high is ignored), then a p12 run with the stale counter at 7.
    push("reset", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'b0, 4'd7);
    push("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'b0, 4'd7);
    f_idle(1'b0, 4'd7);
    f_idle(1'b0, 4'd7);
    f_accept(1'b0, 4'd7);
    f_rounds(0, 0, 11, 1'b0, 1'b0);
    f_done(1'b0, 1'b0);
    f_idle(1'b0, 4'd11);
    // p8 run
    f_accept(1'b1, 4'd11);
    f_rounds(4, 4, 11, 1'b0, 1'b0);
    f_done(1'b0, 1'b0);
    f_idle(1'b0, 4'd11);
    // Back-to-back with start held high; mode toggled while not idle
    f_accept(1'b0, 4'd11);
    f_rounds(0, 0, 11, 1'b1, 1'b1);
    f_done(1'b1, 1'b1);
    f_accept(1'b1, 4'd11);
    f_rounds(4, 4, 11, 1'b1, 1'b0);
    f_done(1'b1, 1'b0);
    f_idle(1'b0, 4'd11);
    // Abort at the third round of p12
    f_accept(1'b0, 4'd11);
    f_rounds(0, 0, 1, 1'b0, 1'b0);
    push("abort", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'b0_1000_0000, 4'd2);
    f_idle(1'b0, 4'd2);
    f_idle(1'b1, 4'd2);
    // Corrupt counter index during ROUND
    f_accept(1'b0, 4'd2);
    f_rounds(0, 0, 1, 1'b0, 1'b0);
    push("range_err", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'b0_1000_0001, 4'd13);
    f_idle(1'b0, 4'd2);
    // Reset pulse at round 5, then a p8 run completes
    f_accept(1'b0, 4'd2);
    f_rounds(0, 0, 4, 1'b0, 1'b0);
    push("reset_mid", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'b0, 4'd5);
    f_idle(1'b0, 4'd5);
    f_accept(1'b1, 4'd5);
    f_rounds(4, 4, 11, 1'b0, 1'b0);
    f_done(1'b0, 1'b0);
    f_idle(1'b0, 4'd11);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock_i);
      reset_i   = vecs[i].rst;
      start_i   = vecs[i].start;
      mode_p8_i = vecs[i].mode;
      abort_i   = vecs[i].abort;
      force_err = vecs[i].frc;
      #1;
      act_ctl = {ready_o, busy_o, en_cpt_o, init_p12_o, init_p8_o,
                 round_en_o, first_round_o, done_o, err_o};
      tests_run++;
      if (act_ctl !== vecs[i].exp_ctl || cpt_i !== vecs[i].exp_cpt) begin
        tests_failed++;
        $display("FAIL %s step %0d: ctl=%b cpt=%0d, expected ctl=%b cpt=%0d",
                 tags[i], i, act_ctl, cpt_i, vecs[i].exp_ctl, vecs[i].exp_cpt);
      end
`ifdef ASCON_ROUND_CONST_EN
      tests_run++;
      if (rc !== vecs[i].exp_rc) begin
        tests_failed++;
        $display("FAIL %s_const step %0d: round_const=%h, expected %h",
                 tags[i], i, rc, vecs[i].exp_rc);
      end
`endif
    end

    @(negedge clock_i);
    start_i = 1'b0;
    abort_i = 1'b0;
    force_err = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
